// File: rtl/gate_demo_pkg.sv
// Board-wide constants shared by the switch conditioning and gate demo blocks.
// Debounce length is derived from the board clock and a millisecond budget.
package gate_demo_pkg;

   localparam int BOARD_CLK_HZ   = 100_000_000;
   localparam int DEB_MS_DEFAULT = 10;
   localparam int SW_CH_DEFAULT  = 2;

   function automatic int deb_cycles_for_ms(input int clk_hz, input int ms);
      return (clk_hz / 1000) * ms;
   endfunction

   localparam int DEB_CYCLES_DEFAULT = deb_cycles_for_ms(BOARD_CLK_HZ, DEB_MS_DEFAULT);

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: two-stage synchronizer, stability counter, clean level
// register and registered single-cycle rise/fall strobes.
module debounce_channel
   import gate_demo_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw,
   output logic clean,
   output logic rise,
   output logic fall
);

   localparam int CNT_W = $clog2(DEB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   // Any return of sync2 to the held level restarts the count, so only an
   // unbroken run of DEB_CYCLES mismatched samples moves the clean level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         clean <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync1 <= sw;
         sync2 <= sync1;
         rise  <= 1'b0;
         fall  <= 1'b0;
         if (sync2 == clean) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            clean <= sync2;
            cnt   <= '0;
            rise  <= sync2;
            fall  <= ~sync2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/switch_debouncer.sv
// Conditions all raw slide-switch inputs; one debounce_channel per switch plus
// a combined change strobe for downstream event logic.
module switch_debouncer
   import gate_demo_pkg::*;
#(
   parameter int N_CH       = SW_CH_DEFAULT,
   parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
   input  logic            I_P_CLK,
   input  logic            I_P_RST_N,
   input  logic [N_CH-1:0] I_P_SW,
   output logic [N_CH-1:0] O_P_SW_CLEAN,
   output logic [N_CH-1:0] O_P_RISE,
   output logic [N_CH-1:0] O_P_FALL,
   output logic            O_P_CHANGE_ANY
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
         .DEB_CYCLES(DEB_CYCLES)
      ) u_ch (
         .clk  (I_P_CLK),
         .rst_n(I_P_RST_N),
         .sw   (I_P_SW[i]),
         .clean(O_P_SW_CLEAN[i]),
         .rise (O_P_RISE[i]),
         .fall (O_P_FALL[i])
      );
   end

   // Strobes are already registered, so this stays a single-cycle pulse even
   // when several channels accept on the same edge.
   assign O_P_CHANGE_ANY = |(O_P_RISE | O_P_FALL);

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer with a sliding-window reference model.
// Directed scenarios first, then randomized switch activity.
module tb_switch_debouncer;

   localparam int N  = 2;
   localparam int D  = 8;

   logic         I_P_CLK;
   logic         I_P_RST_N;
   logic [N-1:0] I_P_SW;
   logic [N-1:0] O_P_SW_CLEAN;
   logic [N-1:0] O_P_RISE;
   logic [N-1:0] O_P_FALL;
   logic         O_P_CHANGE_ANY;

   int vectors;
   int miscompares;

   // Model: history of samples per channel, index 0 = sample taken this edge.
   logic [D+1:0] hist [N];
   logic [N-1:0] exp_clean;
   logic [N-1:0] exp_rise;
   logic [N-1:0] exp_fall;
   logic         exp_any;

   switch_debouncer #(
      .N_CH      (N),
      .DEB_CYCLES(D)
   ) dut (
      .I_P_CLK       (I_P_CLK),
      .I_P_RST_N     (I_P_RST_N),
      .I_P_SW        (I_P_SW),
      .O_P_SW_CLEAN  (O_P_SW_CLEAN),
      .O_P_RISE      (O_P_RISE),
      .O_P_FALL      (O_P_FALL),
      .O_P_CHANGE_ANY(O_P_CHANGE_ANY)
   );

   initial I_P_CLK = 1'b0;
   always #5 I_P_CLK = ~I_P_CLK;

   task automatic modelReset();
      for (int c = 0; c < N; c++) hist[c] = '0;
      exp_clean = '0;
      exp_rise  = '0;
      exp_fall  = '0;
      exp_any   = 1'b0;
   endtask

   // A level is accepted when the D samples seen at the second sync stage
   // (samples two edges old and older) all differ from the current clean level.
   task automatic modelEdge(input logic [N-1:0] sw);
      exp_rise = '0;
      exp_fall = '0;
      if (!I_P_RST_N) begin
         modelReset();
      end else begin
         for (int c = 0; c < N; c++) begin
            hist[c] = {hist[c][D:0], sw[c]};
            if (hist[c][D+1:2] == {D{~exp_clean[c]}}) begin
               exp_clean[c] = ~exp_clean[c];
               if (exp_clean[c]) exp_rise[c] = 1'b1;
               else              exp_fall[c] = 1'b1;
            end
         end
      end
      exp_any = |(exp_rise | exp_fall);
   endtask

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic checkOutput();
      check("clean", O_P_SW_CLEAN, exp_clean);
      check("rise", O_P_RISE, exp_rise);
      check("fall", O_P_FALL, exp_fall);
      check("change_any", {1'b0, O_P_CHANGE_ANY}, {1'b0, exp_any});
   endtask

   // Inputs change 1 ns after a rising edge, so they are stable at the next edge.
   task automatic applyStimulus(input logic [N-1:0] sw);
      I_P_SW = sw;
      @(posedge I_P_CLK);
      modelEdge(sw);
      #1;
      checkOutput();
   endtask

   task automatic hold(input logic [N-1:0] sw, input int cycles);
      for (int k = 0; k < cycles; k++) applyStimulus(sw);
   endtask

   task automatic releaseAndMeasure(input string tag);
      int edges;
      I_P_RST_N = 1'b1;
      edges = 0;
      do begin
         applyStimulus(2'b11);
         edges++;
      end while (O_P_SW_CLEAN !== 2'b11 && edges < 20);
      vectors++;
      assert (edges == D + 2) else begin
         miscompares++;
         $error("[TB] FAIL %s edges_to_clean observed=%0d expected=%0d", tag, edges, D + 2);
      end
      check({tag, "_rise"}, O_P_RISE, 2'b11);
      applyStimulus(2'b11);
      check({tag, "_rise_gone"}, O_P_RISE, 2'b00);
   endtask

   initial begin
      int any_count;
      logic [N-1:0] fall_seen;
      logic [N-1:0] val;
      int run;

      vectors     = 0;
      miscompares = 0;
      I_P_RST_N   = 1'b0;
      I_P_SW      = 2'b11;
      modelReset();
      #2;

      $display("[TB] reset hold with switches high");
      hold(2'b11, 5);
      check("reset_clean_const", O_P_SW_CLEAN, 2'b00);
      releaseAndMeasure("poweron");

      $display("[TB] clean step on channel 0");
      hold(2'b00, 12);
      hold(2'b01, 12);

      $display("[TB] bounce rejection on channel 0");
      hold(2'b00, 12);
      hold(2'b01, 3);
      hold(2'b00, 3);
      hold(2'b01, 3);
      hold(2'b00, 3);
      hold(2'b01, 12);

      $display("[TB] glitches on channel 1");
      hold(2'b00, 12);
      hold(2'b10, 7);
      hold(2'b00, 12);
      hold(2'b10, 8);
      hold(2'b00, 14);

      $display("[TB] simultaneous fall");
      hold(2'b11, 12);
      any_count = 0;
      fall_seen = '0;
      for (int k = 0; k < 14; k++) begin
         applyStimulus(2'b00);
         if (O_P_CHANGE_ANY) any_count++;
         if (O_P_FALL == 2'b11) fall_seen = 2'b11;
      end
      check("simul_fall_both", fall_seen, 2'b11);
      vectors++;
      assert (any_count == 1) else begin
         miscompares++;
         $error("[TB] FAIL simul_change_count observed=%0d expected=%0d", any_count, 1);
      end

      $display("[TB] async reset mid-count");
      hold(2'b11, 5);
      #3;
      I_P_RST_N = 1'b0;
      #1;
      modelReset();
      check("async_rst_clean", O_P_SW_CLEAN, 2'b00);
      check("async_rst_rise", O_P_RISE, 2'b00);
      check("async_rst_fall", O_P_FALL, 2'b00);
      hold(2'b11, 3);
      releaseAndMeasure("after_async");

      $display("[TB] randomized switch activity");
      for (int r = 0; r < 300; r++) begin
         val = N'($urandom_range(0, 3));
         run = $urandom_range(1, 12);
         hold(val, run);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
